zbus_iosync: RTL and testbench

Z80-side I/O port front end for the ZXiznet CPLD, directly downstream of the raw Z80 bus pins. It synchronises the asynchronous Z80 strobes into the internal clock domain and decodes I/O cycles to the card's port. It turns each decoded cycle into a single-cycle write strobe or a read request/acknowledge handshake toward the internal register file. During reads it drives the latched data back onto the Z80 data bus.

---
 rtl/zbus_pkg.sv | 15 +
 rtl/zbus_iosync_if.sv | 25 ++
 rtl/zbus_sync2.sv | 23 ++
 rtl/zbus_iosync.sv | 103 ++++++++++
 tb/tb_zbus_iosync.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/zbus_pkg.sv
// Shared types and defaults for the ZXiznet Z80 I/O front end.
package zbus_pkg;

    localparam logic [7:0] PORT_LO_DEF  = 8'hAB;
    localparam int         REG_BITS_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_RDDONE = 3'd3,
        ST_END    = 3'd4
    } state_t;

endpackage

// File: rtl/zbus_iosync_if.sv
// Register-file side of the Z80 I/O front end: write strobe plus read req/ack handshake.
interface zbus_iosync_if
    import zbus_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEF
) ();

    logic [REG_BITS-1:0] reg_addr;
    logic                wr_stb;
    logic [7:0]          wr_data;
    logic                rd_req;
    logic                rd_ack;
    logic [7:0]          rd_data;

    modport master (
        output reg_addr, wr_stb, wr_data, rd_req,
        input  rd_ack, rd_data
    );

    modport slave (
        input  reg_addr, wr_stb, wr_data, rd_req,
        output rd_ack, rd_data
    );

endinterface

// File: rtl/zbus_sync2.sv
// Parameter-width 2-FF synchroniser; resets to all ones so idle-high strobes read inactive.
module zbus_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/zbus_iosync.sv
// Z80 I/O port front end: strobe sync, port decode, write strobe / read handshake, data drive.
// Optional build macro ZBUS_WAIT_EN: holds Z80 WAIT low during reads until the register file acks.
module zbus_iosync
    import zbus_pkg::*;
#(
    parameter logic [7:0] PORT_LO  = PORT_LO_DEF,
    parameter int         REG_BITS = REG_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] za,
    input  logic [7:0]  zd_in,
    output logic [7:0]  zd_out,
    output logic        zd_oe,
    input  logic        ziorq_n,
    input  logic        zrd_n,
    input  logic        zwr_n,
    input  logic        zm1_n,
    output logic        zwait_n,
    zbus_iosync_if.master rf
);

    logic [3:0] sync_q;
    logic       s_iorq_n, s_rd_n, s_wr_n, s_m1_n;
    logic       port_hit, hit, wr_hit, rd_hit, rd_dec;
    logic       unused_za;

    state_t              state_q, state_d;
    logic [REG_BITS-1:0] reg_addr_q;
    logic [7:0]          wr_data_q;

    zbus_sync2 #(.W(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({ziorq_n, zrd_n, zwr_n, zm1_n}),
        .q     (sync_q)
    );

    assign {s_iorq_n, s_rd_n, s_wr_n, s_m1_n} = sync_q;

    // Address is sampled straight off the pins: the Z80 holds it for the whole strobe.
    assign port_hit  = (za[7:0] == PORT_LO);
    assign hit       = ~s_iorq_n & s_m1_n & (~s_rd_n | ~s_wr_n) & port_hit;
    assign wr_hit    = hit & ~s_wr_n;
    assign rd_hit    = hit & s_wr_n;
    assign unused_za = ^za;

    // Raw-pin read decode so the data bus is released the instant the strobe ends.
    assign rd_dec = rst_n & ~ziorq_n & ~zrd_n & zm1_n & port_hit;
    assign zd_oe  = rd_dec;

`ifdef ZBUS_WAIT_EN
    assign zwait_n = ~(rd_dec & ((state_q == ST_IDLE) || (state_q == ST_RDWAIT)));
`else
    assign zwait_n = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        rf.reg_addr = reg_addr_q;
        rf.wr_data  = wr_data_q;
        rf.wr_stb   = 1'b0;
        rf.rd_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_hit)      state_d = ST_WRITE;
                else if (rd_hit) state_d = ST_RDWAIT;
            end
            ST_WRITE: begin
                rf.wr_stb = 1'b1;
                state_d   = ST_END;
            end
            // Register side always finishes, even if the Z80 has already given up.
            ST_RDWAIT: begin
                rf.rd_req = 1'b1;
                if (rf.rd_ack) state_d = ST_RDDONE;
            end
            ST_RDDONE: state_d = ST_END;
            ST_END: begin
                if (s_iorq_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            zd_out     <= '0;
        end else begin
            if (state_q == ST_IDLE && hit)    reg_addr_q <= za[8+REG_BITS-1:8];
            if (state_q == ST_IDLE && wr_hit) wr_data_q  <= zd_in;
            if (state_q == ST_RDWAIT && rf.rd_ack) zd_out <= rf.rd_data;
        end
    end

endmodule

// File: tb/tb_zbus_iosync.sv
// Directed bench for zbus_iosync: Z80 I/O cycles driven on raw pins, register side modelled inline.
module tb_zbus_iosync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] za;
    logic [7:0]  zd_in;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic        ziorq_n, zrd_n, zwr_n, zm1_n;
    logic        zwait_n;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    logic       rd_req_prev = 1'b0;
    logic [7:0] wr_log [0:15];

    zbus_iosync_if #(.REG_BITS(4)) rf ();

    zbus_iosync #(.PORT_LO(8'hAB), .REG_BITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .za      (za),
        .zd_in   (zd_in),
        .zd_out  (zd_out),
        .zd_oe   (zd_oe),
        .ziorq_n (ziorq_n),
        .zrd_n   (zrd_n),
        .zwr_n   (zwr_n),
        .zm1_n   (zm1_n),
        .zwait_n (zwait_n),
        .rf      (rf.master)
    );

    always #5 clk = ~clk;

    // Pulse/rise counters for the register-side outputs.
    always @(negedge clk) begin
        if (rf.wr_stb) begin
            wr_log[wr_cnt[3:0]] <= rf.wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (rf.rd_req && !rd_req_prev) rd_cnt <= rd_cnt + 1;
        rd_req_prev <= rf.rd_req;
    end

    task automatic pins_idle();
        ziorq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1; zm1_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pins_idle();
        za = 16'h00AB; zd_in = 8'h00;
        rf.rd_ack = 1'b0; rf.rd_data = 8'h00;
        repeat (3) @(negedge clk);
        ziorq_n = 1'b0; zrd_n = 1'b0;
        #1;
        n_checks++; if (zd_oe !== 1'b0) begin n_fail++; $display("FAIL reset_zd_oe got %b exp 0", zd_oe); end
        n_checks++; if (zwait_n !== 1'b1) begin n_fail++; $display("FAIL reset_zwait_n got %b exp 1", zwait_n); end
        n_checks++; if (zd_out !== 8'h00) begin n_fail++; $display("FAIL reset_zd_out got %h exp 00", zd_out); end
        n_checks++; if (rf.wr_stb !== 1'b0 || rf.rd_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes got wr_stb=%b rd_req=%b exp 0 0", rf.wr_stb, rf.rd_req);
        end
        n_checks++; if (rf.reg_addr !== 4'h0 || rf.wr_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_regs got addr=%h data=%h exp 0 00", rf.reg_addr, rf.wr_data);
        end
        pins_idle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Full Z80 OUT cycle with edge-exact strobe timing checks.
    task automatic check_iowr(input logic [15:0] a, input logic [7:0] d, input int gap);
        int w0;
        w0 = wr_cnt;
        @(negedge clk);
        za = a; zd_in = d; ziorq_n = 1'b0; zwr_n = 1'b0;
        #1;
        n_checks++; if (zd_oe !== 1'b0) begin n_fail++; $display("FAIL iowr_zd_oe got %b exp 0", zd_oe); end
        repeat (2) @(negedge clk);
        n_checks++; if (rf.wr_stb !== 1'b0) begin n_fail++; $display("FAIL iowr_stb_early got %b exp 0", rf.wr_stb); end
        @(negedge clk);
        n_checks++; if (rf.wr_stb !== 1'b1) begin n_fail++; $display("FAIL iowr_stb_edge3 got %b exp 1", rf.wr_stb); end
        n_checks++; if (rf.reg_addr !== a[11:8] || rf.wr_data !== d) begin
            n_fail++; $display("FAIL iowr_payload got addr=%h data=%h exp %h %h", rf.reg_addr, rf.wr_data, a[11:8], d);
        end
        @(negedge clk);
        n_checks++; if (rf.wr_stb !== 1'b0) begin n_fail++; $display("FAIL iowr_stb_width got %b exp 0", rf.wr_stb); end
        repeat (4) @(negedge clk);
        pins_idle();
        repeat (gap) @(negedge clk);
        n_checks++; if (wr_cnt !== w0 + 1) begin n_fail++; $display("FAIL iowr_pulse_count got %0d exp %0d", wr_cnt, w0 + 1); end
    endtask

    task automatic test_write();
        int r0;
        r0 = rd_cnt;
        check_iowr(16'h03AB, 8'h99, 4);
        n_checks++; if (rd_cnt !== r0) begin n_fail++; $display("FAIL write_no_rdreq got %0d exp %0d", rd_cnt, r0); end
    endtask

    task automatic test_read();
        int r0, k;
        r0 = rd_cnt;
        @(negedge clk);
        za = 16'h05AB; ziorq_n = 1'b0; zrd_n = 1'b0;
        #1;
        n_checks++; if (zd_oe !== 1'b1) begin n_fail++; $display("FAIL read_oe_on got %b exp 1", zd_oe); end
`ifndef ZBUS_WAIT_EN
        n_checks++; if (zwait_n !== 1'b1) begin n_fail++; $display("FAIL read_zwait_tied got %b exp 1", zwait_n); end
`endif
        k = 0;
        while (!rf.rd_req && k < 10) begin @(negedge clk); k++; end
        n_checks++; if (k !== 3) begin n_fail++; $display("FAIL read_req_latency got %0d exp 3", k); end
        n_checks++; if (rf.reg_addr !== 4'h5) begin n_fail++; $display("FAIL read_reg_addr got %h exp 5", rf.reg_addr); end
        repeat (2) @(negedge clk);
        n_checks++; if (rf.rd_req !== 1'b1) begin n_fail++; $display("FAIL read_req_held got %b exp 1", rf.rd_req); end
        rf.rd_ack = 1'b1; rf.rd_data = 8'h5A;
        @(negedge clk);
        rf.rd_ack = 1'b0; rf.rd_data = 8'h00;
        n_checks++; if (rf.rd_req !== 1'b0 || zd_out !== 8'h5A) begin
            n_fail++; $display("FAIL read_ack got rd_req=%b zd_out=%h exp 0 5a", rf.rd_req, zd_out);
        end
        n_checks++; if (zd_oe !== 1'b1) begin n_fail++; $display("FAIL read_oe_hold got %b exp 1", zd_oe); end
        repeat (2) @(negedge clk);
        pins_idle();
        #1;
        n_checks++; if (zd_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe_release got %b exp 0", zd_oe); end
        repeat (4) @(negedge clk);
        n_checks++; if (rd_cnt !== r0 + 1 || zd_out !== 8'h5A) begin
            n_fail++; $display("FAIL read_once got reqs=%0d zd_out=%h exp %0d 5a", rd_cnt - r0, zd_out, 1);
        end
    endtask

    task automatic test_ack_outside();
        @(negedge clk);
        rf.rd_ack = 1'b1; rf.rd_data = 8'hFF;
        @(negedge clk);
        rf.rd_ack = 1'b0; rf.rd_data = 8'h00;
        @(negedge clk);
        n_checks++; if (zd_out !== 8'h5A) begin n_fail++; $display("FAIL stray_ack got zd_out=%h exp 5a", zd_out); end
    endtask

    // Non-matching cycles: port mismatch, memory write, INTA.
    task automatic test_ignore();
        int w0, r0;
        logic [15:0] av [0:3];
        logic [3:0]  ctl [0:3]; // {iorq_n, rd_n, wr_n, m1_n}
        logic oe_seen;
        av[0] = 16'h2222; ctl[0] = 4'b0101;
        av[1] = 16'h1234; ctl[1] = 4'b1101;
        av[2] = 16'h00AB; ctl[2] = 4'b0110;
        av[3] = 16'h2222; ctl[3] = 4'b0011;
        w0 = wr_cnt; r0 = rd_cnt; oe_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            za = av[i]; zd_in = (i == 1) ? 8'hAB : 8'h99;
            {ziorq_n, zrd_n, zwr_n, zm1_n} = ctl[i];
            repeat (8) begin @(negedge clk); oe_seen = oe_seen | zd_oe; end
            pins_idle();
            repeat (4) @(negedge clk);
        end
        n_checks++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL ignore_wr got %0d exp 0", wr_cnt - w0); end
        n_checks++; if (rd_cnt !== r0) begin n_fail++; $display("FAIL ignore_rd got %0d exp 0", rd_cnt - r0); end
        n_checks++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL ignore_oe got %b exp 0", oe_seen); end
    endtask

    task automatic test_reset_rdwait();
        int k;
        @(negedge clk);
        za = 16'h09AB; ziorq_n = 1'b0; zrd_n = 1'b0;
        k = 0;
        while (!rf.rd_req && k < 10) begin @(negedge clk); k++; end
        n_checks++; if (rf.rd_req !== 1'b1) begin n_fail++; $display("FAIL rst_rdwait_entry got %b exp 1", rf.rd_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rf.rd_req !== 1'b0 || zd_out !== 8'h00 || zd_oe !== 1'b0) begin
            n_fail++; $display("FAIL rst_rdwait_drop got rd_req=%b zd_out=%h zd_oe=%b exp 0 00 0", rf.rd_req, zd_out, zd_oe);
        end
        repeat (2) @(negedge clk);
        pins_idle();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_iowr(16'h01AB, 8'h11, 4);
    endtask

    task automatic test_zwait();
`ifdef ZBUS_WAIT_EN
        int k, hi;
        @(negedge clk);
        za = 16'h07AB; ziorq_n = 1'b0; zrd_n = 1'b0;
        #1;
        n_checks++; if (zwait_n !== 1'b0) begin n_fail++; $display("FAIL wait_assert got %b exp 0", zwait_n); end
        k = 0;
        while (!rf.rd_req && k < 10) begin @(negedge clk); k++; end
        hi = 0;
        repeat (40) begin @(negedge clk); if (zwait_n) hi++; end
        n_checks++; if (hi !== 0 || rf.rd_req !== 1'b1) begin
            n_fail++; $display("FAIL wait_hold got high_cycles=%0d rd_req=%b exp 0 1", hi, rf.rd_req);
        end
        rf.rd_ack = 1'b1; rf.rd_data = 8'hC3;
        @(negedge clk);
        rf.rd_ack = 1'b0; rf.rd_data = 8'h00;
        n_checks++; if (zwait_n !== 1'b1 || zd_out !== 8'hC3) begin
            n_fail++; $display("FAIL wait_release got zwait_n=%b zd_out=%h exp 1 c3", zwait_n, zd_out);
        end
        repeat (2) @(negedge clk);
        pins_idle();
        repeat (4) @(negedge clk);
`else
        @(negedge clk);
        za = 16'h07AB; ziorq_n = 1'b0; zrd_n = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (zwait_n !== 1'b1 || rf.rd_req !== 1'b1) begin
            n_fail++; $display("FAIL nowait_tied got zwait_n=%b rd_req=%b exp 1 1", zwait_n, rf.rd_req);
        end
        rf.rd_ack = 1'b1; rf.rd_data = 8'hC3;
        @(negedge clk);
        rf.rd_ack = 1'b0; rf.rd_data = 8'h00;
        n_checks++; if (zd_out !== 8'hC3) begin n_fail++; $display("FAIL nowait_data got %h exp c3", zd_out); end
        pins_idle();
        repeat (4) @(negedge clk);
`endif
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = wr_cnt;
        check_iowr(16'h00AB, 8'h01, 3);
        check_iowr(16'h00AB, 8'h02, 3);
        repeat (2) @(negedge clk);
        n_checks++; if (wr_cnt !== w0 + 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", wr_cnt - w0); end
        n_checks++; if (wr_log[w0[3:0]] !== 8'h01 || wr_log[w0[3:0] + 4'd1] !== 8'h02) begin
            n_fail++; $display("FAIL b2b_data got %h %h exp 01 02", wr_log[w0[3:0]], wr_log[w0[3:0] + 4'd1]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ack_outside();
        test_ignore();
        test_reset_rdwait();
        test_zwait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
